// File: rtl/input_pkg.sv
// -----------------------------------------------------------------------------
// input_pkg
// Shared definitions for the button input handlers.
//   - rep_state_t : per-channel auto-repeat state (IDLE / DELAY / REPEAT)
//   - DEF_*       : default timing constants used by input_repeat_bank
//   - acc_width() : width of the acceleration counter for a given ACCEL_AFTER
// -----------------------------------------------------------------------------
package input_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  localparam int DEF_INITIAL_DELAY = 20;
  localparam int DEF_REPEAT_RATE   = 3;
  localparam int DEF_DEBOUNCE      = 4;
  localparam int DEF_ACCEL_AFTER   = 8;
  localparam int DEF_FAST_RATE     = 1;

  // Enough bits to hold 0..accel_after; never narrower than one bit.
  function automatic int acc_width(input int accel_after);
    int w;
    if (accel_after <= 0) begin
      w = 1;
    end else begin
      w = $clog2(accel_after + 1);
    end
    return w;
  endfunction

endpackage

// File: rtl/input_repeat_chan.sv
// -----------------------------------------------------------------------------
// input_repeat_chan
// One button channel: 2-flop synchroniser, optional debounce filter and the
// IDLE/DELAY/REPEAT auto-repeat state machine.
//
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   raw_signal : asynchronous button level, active high
//   repeat_en  : auto-repeat enable, sampled every cycle
//   signal     : one-cycle pulse on press and on every repeat (registered)
//   held       : filtered button level
//
// Build option: INPUT_REPEAT_DEBOUNCE_EN
//   defined   -> held follows the synchronised level only after DEBOUNCE
//                consecutive differing cycles
//   undefined -> held is the synchronised level itself, DEBOUNCE is ignored
// -----------------------------------------------------------------------------
module input_repeat_chan
  import input_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  parameter int INITIAL_DELAY = DEF_INITIAL_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int ACCEL_AFTER   = DEF_ACCEL_AFTER,
  parameter int FAST_RATE     = DEF_FAST_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_signal,
  input  logic repeat_en,
  output logic signal,
  output logic held
);

  localparam int               ACC_W      = acc_width(ACCEL_AFTER);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(INITIAL_DELAY - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] FAST_LAST  = CNT_W'(FAST_RATE - 1);
  localparam logic [ACC_W-1:0] ACC_MAX    = ACC_W'(ACCEL_AFTER);
  localparam bit               ACCEL_ON   = (ACCEL_AFTER != 0);

  // Reject parameter sets whose counters could not represent the timing.
  if (DEBOUNCE < 1 || DEBOUNCE > 255 ||
      INITIAL_DELAY < 1 || INITIAL_DELAY > (2**CNT_W - 1) ||
      REPEAT_RATE < 1 || REPEAT_RATE > (2**CNT_W - 1) ||
      FAST_RATE < 1 || FAST_RATE > REPEAT_RATE || ACCEL_AFTER < 0) begin : g_param_err
    $error("input_repeat_chan: illegal parameter combination");
  end

  logic             sync1_r;
  logic             sync2_r;
  logic             held_s;
  logic             held_d_r;
  rep_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] acc_r;
  logic             pulse_r;
  logic             rise_s;
  logic             fall_s;
  logic             fast_s;
  logic [CNT_W-1:0] rep_last_s;

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw_signal;
      sync2_r <= sync1_r;
    end
  end

`ifdef INPUT_REPEAT_DEBOUNCE_EN
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  logic [7:0] db_r;
  logic       held_r;

  // Debounce: the filtered level flips on the DEBOUNCE-th consecutive
  // cycle in which the synchronised level disagrees with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_r   <= 8'd0;
      held_r <= 1'b0;
    end else if (sync2_r != held_r) begin
      if (db_r == DB_LAST) begin
        held_r <= sync2_r;
        db_r   <= 8'd0;
      end else begin
        db_r <= db_r + 8'd1;
      end
    end else begin
      db_r <= 8'd0;
    end
  end

  assign held_s = held_r;
`else
  assign held_s = sync2_r;
`endif

  assign rise_s = held_s & ~held_d_r;
  assign fall_s = ~held_s & held_d_r;
  assign fast_s = ACCEL_ON && (acc_r >= ACC_MAX);

  // Last count value of the current repeat period.
  always_comb begin
    rep_last_s = SLOW_LAST;
    if (fast_s) begin
      rep_last_s = FAST_LAST;
    end else begin
      rep_last_s = SLOW_LAST;
    end
  end

  // Auto-repeat state machine. A falling edge of held takes priority over
  // everything so a repeat due in the release cycle is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_d_r <= 1'b0;
      state_r  <= IDLE;
      cnt_r    <= '0;
      acc_r    <= '0;
      pulse_r  <= 1'b0;
    end else begin
      held_d_r <= held_s;
      pulse_r  <= 1'b0;
      if (fall_s) begin
        state_r <= IDLE;
        cnt_r   <= '0;
        acc_r   <= '0;
      end else begin
        case (state_r)
          IDLE: begin
            if (rise_s) begin
              pulse_r <= 1'b1;
              cnt_r   <= '0;
              acc_r   <= '0;
              state_r <= DELAY;
            end else begin
              state_r <= IDLE;
            end
          end
          DELAY: begin
            if (cnt_r == DELAY_LAST) begin
              if (repeat_en) begin
                pulse_r <= 1'b1;
                cnt_r   <= '0;
                state_r <= REPEAT;
              end else begin
                cnt_r <= DELAY_LAST;
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          REPEAT: begin
            // >= keeps the count saturated even if the period shrinks.
            if (cnt_r >= rep_last_s) begin
              if (repeat_en) begin
                pulse_r <= 1'b1;
                cnt_r   <= '0;
                if (acc_r < ACC_MAX) begin
                  acc_r <= acc_r + ACC_W'(1);
                end else begin
                  acc_r <= acc_r;
                end
              end else begin
                cnt_r <= rep_last_s;
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
            acc_r   <= '0;
          end
        endcase
      end
    end
  end

  assign signal = pulse_r;
  assign held   = held_s;

endmodule

// File: rtl/input_repeat_bank.sv
// -----------------------------------------------------------------------------
// input_repeat_bank
// N_CH independent button channels, each with synchroniser, debounce and
// auto-repeat with optional acceleration.
//
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   raw_signal : [N_CH] asynchronous button levels, active high
//   repeat_en  : [N_CH] per-channel auto-repeat enable
//   signal     : [N_CH] one-cycle press / repeat pulses
//   held       : [N_CH] filtered button levels
//
// Build option: INPUT_REPEAT_DEBOUNCE_EN enables the debounce filter in
// every channel; without it held is the synchronised level.
// -----------------------------------------------------------------------------
module input_repeat_bank
  import input_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 8,
  parameter int DEBOUNCE      = DEF_DEBOUNCE,
  parameter int INITIAL_DELAY = DEF_INITIAL_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int ACCEL_AFTER   = DEF_ACCEL_AFTER,
  parameter int FAST_RATE     = DEF_FAST_RATE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] raw_signal,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] signal,
  output logic [N_CH-1:0] held
);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    input_repeat_chan #(
      .CNT_W        (CNT_W),
      .DEBOUNCE     (DEBOUNCE),
      .INITIAL_DELAY(INITIAL_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .ACCEL_AFTER  (ACCEL_AFTER),
      .FAST_RATE    (FAST_RATE)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_signal(raw_signal[g]),
      .repeat_en (repeat_en[g]),
      .signal    (signal[g]),
      .held      (held[g])
    );
  end

endmodule

// File: tb/tb_input_repeat_bank.sv
// -----------------------------------------------------------------------------
// tb_input_repeat_bank
// Self-checking bench for input_repeat_bank with default parameters.
// The reference model tracks, per channel, the synchronised level, the
// filtered level, the time since the last pulse and the number of repeats,
// and derives every expected pulse from those quantities.
// -----------------------------------------------------------------------------
module tb_input_repeat_bank;

  localparam int N    = 4;
  localparam int ID   = 20;
  localparam int RATE = 3;
  localparam int ACC  = 8;
  localparam int FAST = 1;
  localparam int DEBV = 4;
`ifdef INPUT_REPEAT_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
  localparam int LAT    = DEBV;
`else
  localparam bit DEB_EN = 1'b0;
  localparam int LAT    = 0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] raw_signal;
  logic [N-1:0] repeat_en;
  logic [N-1:0] signal;
  logic [N-1:0] held;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [N-1:0] m_s1, m_s2, m_hdb, m_hprev, m_act;
  logic [N-1:0] exp_sig, exp_held;
  int           m_run[N];
  int           m_since[N];
  int           m_reps[N];

  always #5 clk = ~clk;

  input_repeat_bank #(
    .N_CH(N), .CNT_W(8), .DEBOUNCE(DEBV), .INITIAL_DELAY(ID),
    .REPEAT_RATE(RATE), .ACCEL_AFTER(ACC), .FAST_RATE(FAST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .raw_signal(raw_signal),
    .repeat_en(repeat_en), .signal(signal), .held(held)
  );

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_hdb = '0; m_hprev = '0; m_act = '0;
    exp_sig = '0; exp_held = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c] = 0; m_since[c] = 0; m_reps[c] = 0;
    end
  endtask

  // Advance the model by one clock edge using the inputs sampled at it.
  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      logic lvl;
      logic p;
      int   need;
      lvl = DEB_EN ? m_hdb[c] : m_s2[c];
      p = 1'b0;
      if (!lvl && m_hprev[c]) begin
        m_act[c] = 1'b0;
      end else if (lvl && !m_hprev[c]) begin
        p = 1'b1; m_act[c] = 1'b1; m_since[c] = 0; m_reps[c] = 0;
      end else if (m_act[c]) begin
        m_since[c]++;
        if (m_reps[c] == 0) need = ID;
        else if (ACC != 0 && (m_reps[c] - 1) >= ACC) need = FAST;
        else need = RATE;
        if (m_since[c] >= need && repeat_en[c]) begin
          p = 1'b1; m_since[c] = 0;
          if (m_reps[c] < 1000) m_reps[c]++;
        end
      end
      exp_sig[c] = p;
      m_hprev[c] = lvl;
      if (m_s2[c] != m_hdb[c]) begin
        m_run[c]++;
        if (m_run[c] >= DEBV) begin
          m_hdb[c] = m_s2[c]; m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = raw_signal[c];
    end
    exp_held = DEB_EN ? m_hdb : m_s2;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; raw_signal = '0; repeat_en = '1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (signal !== 4'b0000) begin errors++; $display("FAIL reset_signal got=%b exp=0000", signal); end
    checks++;
    if (held !== 4'b0000) begin errors++; $display("FAIL reset_held got=%b exp=0000", held); end
    for (int t = 0; t < 3; t++) tick();
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (signal !== exp_sig || held !== exp_held)
        begin errors++; $display("FAIL reset_idle sig=%b/%b held=%b/%b", signal, exp_sig, held, exp_held); end
    end
  endtask

  task automatic test_single_press();
    int pq[$];
    int fall_t;
    fall_t = -1;
    raw_signal[0] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      if (t == 11) raw_signal[0] = 1'b0;
      tick();
      checks++;
      if (signal !== exp_sig) begin errors++; $display("FAIL single_sig t=%0d got=%b exp=%b", t, signal, exp_sig); end
      checks++;
      if (held !== exp_held) begin errors++; $display("FAIL single_held t=%0d got=%b exp=%b", t, held, exp_held); end
      if (signal[0]) pq.push_back(t);
      if (t > 10 && !held[0] && fall_t < 0) fall_t = t - 10;
    end
    checks++;
    if (pq.size() != 1) begin errors++; $display("FAIL single_count got=%0d exp=1", pq.size()); end
    checks++;
    if (pq.size() == 0 || pq[0] != 3 + LAT)
      begin errors++; $display("FAIL single_time got=%0d exp=%0d", (pq.size() > 0) ? pq[0] : -1, 3 + LAT); end
    checks++;
    if (fall_t != 2 + LAT) begin errors++; $display("FAIL single_release got=%0d exp=%0d", fall_t, 2 + LAT); end
  endtask

  task automatic test_accel();
    int pq[$];
    int exp_rel[12] = '{0, 20, 23, 26, 29, 32, 35, 38, 41, 44, 45, 46};
    raw_signal[1] = 1'b1;
    for (int t = 1; t <= 125; t++) begin
      if (t == 101) raw_signal[1] = 1'b0;
      tick();
      checks++;
      if (signal !== exp_sig) begin errors++; $display("FAIL accel_sig t=%0d got=%b exp=%b", t, signal, exp_sig); end
      checks++;
      if (held !== exp_held) begin errors++; $display("FAIL accel_held t=%0d got=%b exp=%b", t, held, exp_held); end
      if (signal[1]) pq.push_back(t);
    end
    checks++;
    if (pq.size() != 65) begin errors++; $display("FAIL accel_count got=%0d exp=65", pq.size()); end
    for (int i = 1; i < 12; i++) begin
      checks++;
      if (pq.size() <= i || (pq[i] - pq[0]) != exp_rel[i])
        begin errors++; $display("FAIL accel_spacing idx=%0d got=%0d exp=%0d", i, (pq.size() > i) ? pq[i] - pq[0] : -1, exp_rel[i]); end
    end
  endtask

  task automatic test_glitch();
    int np;
    int nh;
    for (int len = 3; len <= 4; len++) begin
      np = 0; nh = 0;
      raw_signal[2] = 1'b1;
      for (int t = 1; t <= 20; t++) begin
        if (t == len + 1) raw_signal[2] = 1'b0;
        tick();
        checks++;
        if (signal !== exp_sig || held !== exp_held)
          begin errors++; $display("FAIL glitch_model t=%0d sig=%b/%b held=%b/%b", t, signal, exp_sig, held, exp_held); end
        if (signal[2]) np++;
        if (held[2]) nh++;
      end
      checks++;
      if (np != ((len == 3 && DEB_EN) ? 0 : 1))
        begin errors++; $display("FAIL glitch_pulses len=%0d got=%0d exp=%0d", len, np, (len == 3 && DEB_EN) ? 0 : 1); end
      checks++;
      if (nh != ((len == 3 && DEB_EN) ? 0 : len))
        begin errors++; $display("FAIL glitch_held len=%0d got=%0d exp=%0d", len, nh, (len == 3 && DEB_EN) ? 0 : len); end
    end
  endtask

  task automatic test_release_boundary();
    int pq[$];
    int exp_rel[4] = '{0, 20, 23, 26};
    int hold_len[3] = '{20, 80, 40};
    for (int ph = 0; ph < 3; ph++) begin
      pq.delete();
      raw_signal[0] = 1'b1;
      for (int t = 1; t <= hold_len[ph] + 20; t++) begin
        if (t == hold_len[ph] + 1) raw_signal[0] = 1'b0;
        tick();
        checks++;
        if (signal !== exp_sig || held !== exp_held)
          begin errors++; $display("FAIL boundary_model ph=%0d t=%0d sig=%b/%b held=%b/%b", ph, t, signal, exp_sig, held, exp_held); end
        if (signal[0]) pq.push_back(t);
      end
      if (ph == 0) begin
        checks++;
        if (pq.size() != 1) begin errors++; $display("FAIL boundary_drop got=%0d exp=1", pq.size()); end
      end else if (ph == 2) begin
        for (int i = 1; i < 4; i++) begin
          checks++;
          if (pq.size() <= i || (pq[i] - pq[0]) != exp_rel[i])
            begin errors++; $display("FAIL boundary_repress idx=%0d got=%0d exp=%0d", i, (pq.size() > i) ? pq[i] - pq[0] : -1, exp_rel[i]); end
        end
      end
    end
  endtask

  task automatic test_repeat_gating();
    int pq[$];
    int np;
    np = 0;
    repeat_en[3] = 1'b0;
    raw_signal[3] = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      checks++;
      if (signal !== exp_sig || held !== exp_held)
        begin errors++; $display("FAIL gating_model t=%0d sig=%b/%b held=%b/%b", t, signal, exp_sig, held, exp_held); end
      if (signal[3]) np++;
    end
    checks++;
    if (np != 1) begin errors++; $display("FAIL gating_single got=%0d exp=1", np); end
    repeat_en[3] = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      checks++;
      if (signal !== exp_sig) begin errors++; $display("FAIL gating_sig t=%0d got=%b exp=%b", t, signal, exp_sig); end
      if (signal[3]) pq.push_back(t);
    end
    checks++;
    if (pq.size() < 3 || pq[0] != 1 || pq[1] != 4 || pq[2] != 7)
      begin errors++; $display("FAIL gating_resume got_first=%0d n=%0d exp=1,4,7", (pq.size() > 0) ? pq[0] : -1, pq.size()); end
    raw_signal[3] = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      tick();
      checks++;
      if (signal !== exp_sig || held !== exp_held)
        begin errors++; $display("FAIL gating_release t=%0d sig=%b/%b held=%b/%b", t, signal, exp_sig, held, exp_held); end
    end
  endtask

  task automatic test_concurrent();
    int cnt[N];
    for (int c = 0; c < N; c++) cnt[c] = 0;
    raw_signal = '1;
    for (int t = 1; t <= 80; t++) begin
      if (t == 61) raw_signal = '0;
      tick();
      checks++;
      if (signal !== exp_sig || held !== exp_held)
        begin errors++; $display("FAIL conc_model t=%0d sig=%b/%b held=%b/%b", t, signal, exp_sig, held, exp_held); end
      for (int c = 0; c < N; c++) if (signal[c]) cnt[c]++;
    end
    for (int c = 0; c < N; c++) begin
      checks++;
      if (cnt[c] != 25) begin errors++; $display("FAIL conc_count ch=%0d got=%0d exp=25", c, cnt[c]); end
    end
  endtask

  task automatic test_reset_mid();
    int first;
    first = -1;
    raw_signal = '1;
    for (int t = 1; t <= 30; t++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (signal !== 4'b0000 || held !== 4'b0000)
      begin errors++; $display("FAIL midreset_async sig=%b held=%b exp=0000", signal, held); end
    model_reset();
    for (int t = 0; t < 3; t++) tick();
    rst_n = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      checks++;
      if (signal !== exp_sig || held !== exp_held)
        begin errors++; $display("FAIL midreset_model t=%0d sig=%b/%b held=%b/%b", t, signal, exp_sig, held, exp_held); end
      if (signal[0] && first < 0) first = t;
    end
    checks++;
    if (first != 3 + LAT) begin errors++; $display("FAIL midreset_repress got=%0d exp=%0d", first, 3 + LAT); end
    raw_signal = '0;
    for (int t = 0; t < 15; t++) tick();
  endtask

  task automatic test_random();
    int timer[N];
    for (int c = 0; c < N; c++) timer[c] = $urandom_range(1, 40);
    for (int t = 1; t <= 1500; t++) begin
      for (int c = 0; c < N; c++) begin
        timer[c]--;
        if (timer[c] <= 0) begin
          raw_signal[c] = ~raw_signal[c];
          timer[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 90);
        end
        if ($urandom_range(0, 15) == 0) repeat_en[c] = ~repeat_en[c];
      end
      tick();
      checks++;
      if (signal !== exp_sig) begin errors++; $display("FAIL random_sig t=%0d got=%b exp=%b", t, signal, exp_sig); end
      checks++;
      if (held !== exp_held) begin errors++; $display("FAIL random_held t=%0d got=%b exp=%b", t, held, exp_held); end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_accel();
    test_glitch();
    test_release_boundary();
    test_repeat_gating();
    test_concurrent();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/input_repeat_bank.md
# input_repeat_bank

Multi-channel successor to the single-button edge/auto-repeat handler. Each of `N_CH` raw button inputs is synchronised and debounced, then drives its own IDLE/DELAY/REPEAT state machine. Each channel emits a one-cycle `pulse` on press, repeats after an initial delay, and optionally speeds up after a configurable number of repeats. Sits between the board button pins and the game control logic (move/rotate/drop), replacing one handler instance per button.

## Interface
- `N_CH`, 4, number of independent channels
- `CNT_W`, 8, width of the per-channel timing counter
- `DEBOUNCE`, 4, consecutive stable cycles required before the filtered level changes (1..255)
- `INITIAL_DELAY`, 20, cycles from the press pulse to the first repeat pulse (1..2^CNT_W-1)
- `REPEAT_RATE`, 3, cycles between repeat pulses before acceleration (1..2^CNT_W-1)
- `ACCEL_AFTER`, 8, number of repeat pulses before switching to `FAST_RATE`; 0 disables acceleration
- `FAST_RATE`, 1, cycles between repeat pulses after acceleration (1..REPEAT_RATE)

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `raw_signal` in N_CH: asynchronous button levels, active high.
- `repeat_en` in N_CH: per-channel auto-repeat enable. Sampled every cycle.
- `signal` out N_CH: one-cycle pulses (press and repeats).
- `held` out N_CH: filtered, debounced level.

## Operation
- **Reset:** `signal`, `held`, all synchroniser flops, debounce and timing counters, and the acceleration count are 0. All channels are in IDLE.
- **Synchroniser:** each channel has a 2-flop synchroniser, giving the synchronised level `s`.
- **Debounce:**
  - Counter `db` counts consecutive cycles in which `s != held`.
  - When `db` reaches `DEBOUNCE`, `held <= s` and `db <= 0`.
  - Any cycle with `s == held` clears `db`.
- **FSM, per channel, registered outputs:**
  - IDLE: on a rising edge of `held`, pulse `signal`, set `cnt=0`, clear `acc`, go to DELAY.
  - DELAY:
    - Increments `cnt` each cycle.
    - When `cnt == INITIAL_DELAY-1` and `repeat_en`: pulse, `cnt=0`, go to REPEAT.
    - If `repeat_en` is low, stay in DELAY with `cnt` saturated at `INITIAL_DELAY-1`; no pulses.
  - REPEAT:
    - Increments `cnt`.
    - Period `P = (ACCEL_AFTER!=0 && acc>=ACCEL_AFTER) ? FAST_RATE : REPEAT_RATE`.
    - When `cnt == P-1` and `repeat_en`: pulse, `cnt=0`, and `acc` increments, saturating at `ACCEL_AFTER`.
    - If `repeat_en` is low, no pulses; `cnt` saturates at `P-1`.
  - Any state: a falling edge of `held` returns the channel to IDLE and clears `cnt` and `acc`. Release wins over a repeat due in the same cycle, so no pulse is emitted.
- **Channel independence:** channels are fully independent; simultaneous presses produce simultaneous pulses.
- **Counter widths:** `cnt` is `CNT_W` bits and never wraps (it is cleared or saturated). `acc` is `$clog2(ACCEL_AFTER+1)` bits (minimum 1).

## Timing
- Count the edge that first samples `raw_signal` high as edge 1:
  - `s` is high after edge 2.
  - `held` is high after edge 2+DEBOUNCE.
  - `signal` is high for exactly one cycle after edge 3+DEBOUNCE.
- Release follows the same path: `held` falls 2+DEBOUNCE edges after `raw_signal` is first sampled low.
- Pulse spacing while held: the first repeat is `INITIAL_DELAY` cycles after the press pulse. Subsequent repeats are `REPEAT_RATE` cycles apart, then `FAST_RATE` cycles apart once `ACCEL_AFTER` repeats have been emitted.
- Raising `repeat_en` while saturated: the pulse fires on the next cycle.
- A glitch shorter than `DEBOUNCE` cycles at `s` produces no change.
- Reset mid-press: all outputs drop asynchronously. After `rst_n` deasserts with the button still held, a fresh press pulse is emitted 3+DEBOUNCE edges later.

## Configuration
- Macro: `INPUT_REPEAT_DEBOUNCE_EN`.
- Defined: the debounce filter is as described.
- Undefined: `held = s` (no `db` counter). The press pulse appears after edge 3, and `DEBOUNCE` is ignored.

## Structure
- Shared package `input_pkg`:
  - FSM state enum `rep_state_t` {IDLE, DELAY, REPEAT}.
  - Default constants `DEF_INITIAL_DELAY`, `DEF_REPEAT_RATE`, `DEF_DEBOUNCE`.
- Sub-module `input_repeat_chan`: one channel (sync, debounce, FSM). The top level instantiates it `N_CH` times in a generate loop.

## Test plan
- **Single press:** defaults, `repeat_en=1`, hold ch0 for 10 cycles → one pulse after edge 7, no repeat, `held` falls 6 edges after release.
- **Repeat with acceleration:** hold ch1 for 100 cycles → pulses at relative cycles 0, 20, 23, 26, …, 44 (8 repeats), then every cycle from 45 until release.
- **Glitch rejection:** a 3-cycle raw high on ch2 → no `held`, no pulse. A 4-cycle stable high → one pulse.
- **Release at a repeat boundary:** release timed so `held` falls in the cycle a repeat is due → no pulse. Re-press → new pulse with `acc` cleared.
- **Repeat gating:** `repeat_en=0` on ch3 during a 40-cycle hold → single press pulse only. Raise `repeat_en` at cycle 40 → pulse next cycle, then every 3 cycles.
- **Concurrency and reset:**
  - All 4 channels pressed on the same edge → identical pulse patterns.
  - `rst_n` low mid-hold → `signal`/`held`=0 immediately, new press pulse 7 edges after release of reset.
